// File: rtl/ctrl_unit.sv
// RV32I main decoder with registered control outputs (one cycle after inst).
// Define CTRL_ILLEGAL_FLAG_EN to add the registered illegal_inst output.
module ctrl_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  output logic [4:0]  alu_ctrl,
  output logic        reg_file_wr_en,
  output logic [1:0]  reg_file_wr_back_sel,
  output logic        alu_op2_sel,
  output logic        d_mem_rd_en,
  output logic        d_mem_wr_en,
  output logic [1:0]  d_mem_size,
  output logic        jal,
  output logic        jalr
`ifdef CTRL_ILLEGAL_FLAG_EN
  ,
  output logic        illegal_inst
`endif
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'b00000,
    ALU_SUB    = 5'b00001,
    ALU_SLL    = 5'b00010,
    ALU_SLT    = 5'b00011,
    ALU_SLTU   = 5'b00100,
    ALU_XOR    = 5'b00101,
    ALU_SRL    = 5'b00110,
    ALU_SRA    = 5'b00111,
    ALU_OR     = 5'b01000,
    ALU_AND    = 5'b01001,
    ALU_PASS_B = 5'b01010
  } alu_e;

  typedef enum logic [1:0] {
    WB_ALU   = 2'b00,
    WB_DMEM  = 2'b01,
    WB_PC4   = 2'b10,
    WB_PCIMM = 2'b11
  } wb_sel_e;

  typedef struct packed {
    logic [4:0] alu;
    logic       rf_wr;
    logic [1:0] wb_sel;
    logic       op2_imm;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] mem_size;
    logic       jal;
    logic       jalr;
  } ctrl_t;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  opcode_e    opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  ctrl_t      ctrl_d;
  ctrl_t      ctrl_q;

  assign opcode = opcode_e'(inst[6:0]);
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  // Register indices and immediates are consumed by the datapath, not here.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{inst[24:15], inst[11:7]};

  // Shared funct3 map for OP/OP-IMM; 101 resolves to SRL until funct7 says SRA.
  function automatic alu_e alu_from_funct3(input logic [2:0] f3);
    alu_e op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    ctrl_d = '0;
    legal  = 1'b0;
    case (opcode)
      OPC_LUI: begin
        legal          = 1'b1;
        ctrl_d.alu     = ALU_PASS_B;
        ctrl_d.op2_imm = 1'b1;
        ctrl_d.rf_wr   = 1'b1;
        ctrl_d.wb_sel  = WB_ALU;
      end
      OPC_AUIPC: begin
        legal          = 1'b1;
        ctrl_d.alu     = ALU_ADD;
        ctrl_d.op2_imm = 1'b1;
        ctrl_d.rf_wr   = 1'b1;
        ctrl_d.wb_sel  = WB_PCIMM;
      end
      OPC_JAL: begin
        legal          = 1'b1;
        ctrl_d.alu     = ALU_ADD;
        ctrl_d.op2_imm = 1'b1;
        ctrl_d.rf_wr   = 1'b1;
        ctrl_d.wb_sel  = WB_PC4;
        ctrl_d.jal     = 1'b1;
      end
      OPC_JALR: begin
        legal          = (funct3 == 3'b000);
        ctrl_d.alu     = ALU_ADD;
        ctrl_d.op2_imm = 1'b1;
        ctrl_d.rf_wr   = 1'b1;
        ctrl_d.wb_sel  = WB_PC4;
        ctrl_d.jalr    = 1'b1;
      end
      OPC_BRANCH: begin
        legal      = (funct3 != 3'b010) && (funct3 != 3'b011);
        ctrl_d.alu = {2'b10, funct3};
      end
      OPC_LOAD: begin
        legal           = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                          (funct3 == 3'b100) || (funct3 == 3'b101);
        ctrl_d.alu      = ALU_ADD;
        ctrl_d.op2_imm  = 1'b1;
        ctrl_d.rf_wr    = 1'b1;
        ctrl_d.wb_sel   = WB_DMEM;
        ctrl_d.mem_rd   = 1'b1;
        ctrl_d.mem_size = funct3[1:0];
      end
      OPC_STORE: begin
        legal           = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        ctrl_d.alu      = ALU_ADD;
        ctrl_d.op2_imm  = 1'b1;
        ctrl_d.mem_wr   = 1'b1;
        ctrl_d.mem_size = funct3[1:0];
      end
      OPC_OPIMM: begin
        ctrl_d.alu     = alu_from_funct3(funct3);
        ctrl_d.op2_imm = 1'b1;
        ctrl_d.rf_wr   = 1'b1;
        ctrl_d.wb_sel  = WB_ALU;
        legal          = 1'b1;
        if (funct3 == 3'b001) begin
          legal = (funct7 == F7_ZERO);
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT) begin
            ctrl_d.alu = ALU_SRA;
          end else begin
            legal = (funct7 == F7_ZERO);
          end
        end
      end
      OPC_OP: begin
        ctrl_d.op2_imm = 1'b0;
        ctrl_d.rf_wr   = 1'b1;
        ctrl_d.wb_sel  = WB_ALU;
        if (funct7 == F7_ZERO) begin
          legal      = 1'b1;
          ctrl_d.alu = alu_from_funct3(funct3);
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            legal      = 1'b1;
            ctrl_d.alu = ALU_SUB;
          end else if (funct3 == 3'b101) begin
            legal      = 1'b1;
            ctrl_d.alu = ALU_SRA;
          end
        end
      end
      default: legal = 1'b0;
    endcase
    // Illegal encodings must not modify any architectural state.
    if (!legal) begin
      ctrl_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

`ifdef CTRL_ILLEGAL_FLAG_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= !legal;
    end
  end

  assign illegal_inst = illegal_q;
`endif

  assign alu_ctrl             = ctrl_q.alu;
  assign reg_file_wr_en       = ctrl_q.rf_wr;
  assign reg_file_wr_back_sel = ctrl_q.wb_sel;
  assign alu_op2_sel          = ctrl_q.op2_imm;
  assign d_mem_rd_en          = ctrl_q.mem_rd;
  assign d_mem_wr_en          = ctrl_q.mem_wr;
  assign d_mem_size           = ctrl_q.mem_size;
  assign jal                  = ctrl_q.jal;
  assign jalr                 = ctrl_q.jalr;

endmodule

// File: tb/tb_ctrl_unit.sv
// Scoreboard bench for ctrl_unit: driver queues hand-computed expectations,
// monitor pops one per clock edge and compares after the outputs settle.
module tb_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic [4:0]  alu_ctrl;
  logic        reg_file_wr_en;
  logic [1:0]  reg_file_wr_back_sel;
  logic        alu_op2_sel;
  logic        d_mem_rd_en;
  logic        d_mem_wr_en;
  logic [1:0]  d_mem_size;
  logic        jal;
  logic        jalr;
`ifdef CTRL_ILLEGAL_FLAG_EN
  logic        illegal_inst;
`endif

  always #5 clk = ~clk;

  ctrl_unit dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .inst                 (inst),
    .alu_ctrl             (alu_ctrl),
    .reg_file_wr_en       (reg_file_wr_en),
    .reg_file_wr_back_sel (reg_file_wr_back_sel),
    .alu_op2_sel          (alu_op2_sel),
    .d_mem_rd_en          (d_mem_rd_en),
    .d_mem_wr_en          (d_mem_wr_en),
    .d_mem_size           (d_mem_size),
    .jal                  (jal),
    .jalr                 (jalr)
`ifdef CTRL_ILLEGAL_FLAG_EN
    ,
    .illegal_inst         (illegal_inst)
`endif
  );

  typedef struct {
    string       name;
    logic [15:0] exp;
    logic        ill;
  } sb_t;

  sb_t         sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [15:0] act;

  // {alu(5), wr_en, sel(2), op2, rd_en, mem_wr, size(2), jal, jalr}
  assign act = {alu_ctrl, reg_file_wr_en, reg_file_wr_back_sel, alu_op2_sel,
                d_mem_rd_en, d_mem_wr_en, d_mem_size, jal, jalr};

  function automatic logic [15:0] ex(input logic [4:0] alu, input logic wr, input logic [1:0] sel,
                                     input logic op2, input logic rd, input logic wm,
                                     input logic [1:0] sz, input logic j, input logic jr);
    return {alu, wr, sel, op2, rd, wm, sz, j, jr};
  endfunction

  localparam logic [15:0] ZERO = 16'h0000;

  task automatic step(input string nm, input logic r, input logic [31:0] iw,
                      input logic [15:0] e, input logic il);
    sb_t item;
    item.name = nm;
    item.exp  = e;
    item.ill  = il;
    rst_n = r;
    inst  = iw;
    sb.push_back(item);
    @(posedge clk);
    #1;
  endtask

  // Monitor: the entry queued before an edge is the one that edge captures.
  initial begin
    sb_t cur;
    logic have;
    forever begin
      @(posedge clk);
      have = 1'b0;
      if (sb.size() > 0) begin
        cur  = sb.pop_front();
        have = 1'b1;
      end
      @(negedge clk);
      if (have) begin
        n_tests++;
        if (act !== cur.exp) begin
          n_fail++;
          $display("FAIL %s: ctrl got %h expected %h", cur.name, act, cur.exp);
        end
`ifdef CTRL_ILLEGAL_FLAG_EN
        n_tests++;
        if (illegal_inst !== cur.ill) begin
          n_fail++;
          $display("FAIL %s illegal_inst: got %b expected %b", cur.name, illegal_inst, cur.ill);
        end
`endif
      end
    end
  end

  initial begin
    step("reset_add",     1'b0, 32'h00000033, ZERO, 1'b0);
    step("first_add",     1'b1, 32'h00000033, ex(5'b00000,1,2'b00,0,0,0,2'b00,0,0), 1'b0);
    step("lui",           1'b1, 32'h80000037, ex(5'b01010,1,2'b00,1,0,0,2'b00,0,0), 1'b0);
    step("jal",           1'b1, 32'h8020006F, ex(5'b00000,1,2'b10,1,0,0,2'b00,1,0), 1'b0);
    step("jalr",          1'b1, 32'h00008067, ex(5'b00000,1,2'b10,1,0,0,2'b00,0,1), 1'b0);
    step("jalr_bad_f3",   1'b1, 32'h00009067, ZERO, 1'b1);
    step("auipc",         1'b1, 32'h00000017, ex(5'b00000,1,2'b11,1,0,0,2'b00,0,0), 1'b0);
    step("beq",           1'b1, 32'h800000E3, ex(5'b10000,0,2'b00,0,0,0,2'b00,0,0), 1'b0);
    step("bgeu",          1'b1, 32'h00007063, ex(5'b10111,0,2'b00,0,0,0,2'b00,0,0), 1'b0);
    step("branch_f3_010", 1'b1, 32'h00002063, ZERO, 1'b1);
    step("lb",            1'b1, 32'h80000003, ex(5'b00000,1,2'b01,1,1,0,2'b00,0,0), 1'b0);
    step("lw",            1'b1, 32'h00002003, ex(5'b00000,1,2'b01,1,1,0,2'b10,0,0), 1'b0);
    step("lhu",           1'b1, 32'h00005003, ex(5'b00000,1,2'b01,1,1,0,2'b01,0,0), 1'b0);
    step("load_f3_011",   1'b1, 32'h00003003, ZERO, 1'b1);
    step("sb",            1'b1, 32'h80000823, ex(5'b00000,0,2'b00,1,0,1,2'b00,0,0), 1'b0);
    step("sw",            1'b1, 32'h00002023, ex(5'b00000,0,2'b00,1,0,1,2'b10,0,0), 1'b0);
    step("store_f3_011",  1'b1, 32'h00003023, ZERO, 1'b1);
    step("addi_neg",      1'b1, 32'hFFF00013, ex(5'b00000,1,2'b00,1,0,0,2'b00,0,0), 1'b0);
    step("slti",          1'b1, 32'h00002013, ex(5'b00011,1,2'b00,1,0,0,2'b00,0,0), 1'b0);
    step("sltiu",         1'b1, 32'h80003013, ex(5'b00100,1,2'b00,1,0,0,2'b00,0,0), 1'b0);
    step("xori",          1'b1, 32'h00004013, ex(5'b00101,1,2'b00,1,0,0,2'b00,0,0), 1'b0);
    step("ori",           1'b1, 32'h00006013, ex(5'b01000,1,2'b00,1,0,0,2'b00,0,0), 1'b0);
    step("andi",          1'b1, 32'h00007013, ex(5'b01001,1,2'b00,1,0,0,2'b00,0,0), 1'b0);
    step("slli",          1'b1, 32'h00101013, ex(5'b00010,1,2'b00,1,0,0,2'b00,0,0), 1'b0);
    step("srli",          1'b1, 32'h00105013, ex(5'b00110,1,2'b00,1,0,0,2'b00,0,0), 1'b0);
    step("srai",          1'b1, 32'h41005013, ex(5'b00111,1,2'b00,1,0,0,2'b00,0,0), 1'b0);
    step("slli_f7_alt",   1'b1, 32'h40001013, ZERO, 1'b1);
    step("srli_f7_bad",   1'b1, 32'h02005013, ZERO, 1'b1);
    step("sub",           1'b1, 32'h40000033, ex(5'b00001,1,2'b00,0,0,0,2'b00,0,0), 1'b0);
    step("sra",           1'b1, 32'h40005033, ex(5'b00111,1,2'b00,0,0,0,2'b00,0,0), 1'b0);
    step("sll",           1'b1, 32'h00001033, ex(5'b00010,1,2'b00,0,0,0,2'b00,0,0), 1'b0);
    step("srl",           1'b1, 32'h00005033, ex(5'b00110,1,2'b00,0,0,0,2'b00,0,0), 1'b0);
    step("sltu",          1'b1, 32'h00003033, ex(5'b00100,1,2'b00,0,0,0,2'b00,0,0), 1'b0);
    step("and",           1'b1, 32'h00007033, ex(5'b01001,1,2'b00,0,0,0,2'b00,0,0), 1'b0);
    step("op_alt_f3_001", 1'b1, 32'h40001033, ZERO, 1'b1);
    step("mul",           1'b1, 32'h02000033, ZERO, 1'b1);
    step("all_zero",      1'b1, 32'h00000000, ZERO, 1'b1);
    step("fence",         1'b1, 32'h0000000F, ZERO, 1'b1);
    step("ecall",         1'b1, 32'h00000073, ZERO, 1'b1);
    step("or",            1'b1, 32'h00006033, ex(5'b01000,1,2'b00,0,0,0,2'b00,0,0), 1'b0);
    step("reset_mid_lui", 1'b0, 32'h80000037, ZERO, 1'b0);
    step("reset_mid_bad", 1'b0, 32'h00000000, ZERO, 1'b0);
    step("auipc_after",   1'b1, 32'h00000017, ex(5'b00000,1,2'b11,1,0,0,2'b00,0,0), 1'b0);
    step("xor_b2b",       1'b1, 32'h00004033, ex(5'b00101,1,2'b00,0,0,0,2'b00,0,0), 1'b0);
    repeat (2) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
